// File: rtl/plab5_mcore_tdm_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plab5_mcore_tdm_mem_arb_pkg
//  Purpose  : Shared defines, port-ID encodings and width helpers for the
//             security-domain-aware TDM memory arbiter.
//             Optional feature macro: PLAB5_MCORE_TDM_ARB_WORK_CONSERVE_EN
//  Revision : 1.0  initial release
// ============================================================================

`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_, a_, d_) (3 + (o_) + (a_) + $clog2((d_) / 8) + (d_))
`endif

`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_, d_) (3 + (o_) + $clog2((d_) / 8) + (d_))
`endif

`ifndef PLAB5_MCORE_TDM_PORT0
`define PLAB5_MCORE_TDM_PORT0 1'b0
`endif

`ifndef PLAB5_MCORE_TDM_PORT1
`define PLAB5_MCORE_TDM_PORT1 1'b1
`endif

package plab5_mcore_tdm_mem_arb_pkg;

    // Identifies which requesting port owns a slot / an outstanding request.
    typedef enum logic {
        PORT_P0 = `PLAB5_MCORE_TDM_PORT0,
        PORT_P1 = `PLAB5_MCORE_TDM_PORT1
    } port_id_e;

    // Control (non-data) width of a memory request message.
    function automatic int unsigned req_ctrl_nbits(input int unsigned o,
                                                   input int unsigned a,
                                                   input int unsigned l);
        return `VC_MEM_REQ_MSG_NBITS(o, a, l) - l;
    endfunction

    // Control (non-data) width of a memory response message.
    function automatic int unsigned resp_ctrl_nbits(input int unsigned o,
                                                    input int unsigned l);
        return `VC_MEM_RESP_MSG_NBITS(o, l) - l;
    endfunction

    // The port that does not own the current slot.
    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_P0) ? PORT_P1 : PORT_P0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plab5_mcore_tdm_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : plab5_mcore_tdm_mem_arb_if
//  Purpose  : One val/rdy memory message channel (control, data, domain).
//             master drives the message, slave returns rdy.
//  Revision : 1.0  initial release
// ============================================================================
interface plab5_mcore_tdm_mem_arb_if
    import plab5_mcore_tdm_mem_arb_pkg::*;
#(
    parameter int unsigned p_ctrl_nbits = req_ctrl_nbits(8, 32, 128),
    parameter int unsigned p_data_nbits = 128
);
    logic [p_ctrl_nbits-1:0] control;
    logic [p_data_nbits-1:0] data;
    logic                    domain;
    logic                    val;
    logic                    rdy;

    modport master (output control, output data, output domain, output val, input rdy);
    modport slave  (input control, input data, input domain, input val, output rdy);
endinterface
`default_nettype wire

// File: rtl/plab5_mcore_tdm_owner_queue.sv
`default_nettype none
// ============================================================================
//  Module   : plab5_mcore_tdm_owner_queue
//  Purpose  : 1-bit wide FIFO remembering which port issued each outstanding
//             memory request, so in-order responses can be steered back.
//  Revision : 1.0  initial release
// ============================================================================
module plab5_mcore_tdm_owner_queue
    import plab5_mcore_tdm_mem_arb_pkg::*;
#(
    parameter int unsigned p_depth = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    // A depth of 1 still gets a 1-bit pointer; storage is sized to the
    // pointer range so wrap-around is free for any power-of-2 depth.
    localparam int unsigned ptr_nbits  = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned store_size = 1 << ptr_nbits;
    localparam logic [ptr_nbits:0] depth_cnt = p_depth[ptr_nbits:0];

    logic [store_size-1:0] entries;
    logic [ptr_nbits-1:0]  wr_ptr;
    logic [ptr_nbits-1:0]  rd_ptr;
    logic [ptr_nbits:0]    count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == depth_cnt);
    assign empty   = (count == '0);
    assign head    = entries[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer, occupancy and storage update; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/plab5_mcore_tdm_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : plab5_mcore_tdm_mem_arb
//  Purpose  : Time-division-multiplexed arbiter sharing one memory port
//             between two requesting ports. Slot ownership depends only on a
//             free-running slot counter, so one port's traffic never shifts
//             the other's grant timing. Responses are steered back through an
//             in-order owner queue.
//             Optional feature macro: PLAB5_MCORE_TDM_ARB_WORK_CONSERVE_EN
//             (lets the non-owner use an idle slot; leaks timing, non-secure
//             builds only).
//  Revision : 1.0  initial release
// ============================================================================
module plab5_mcore_tdm_mem_arb
    import plab5_mcore_tdm_mem_arb_pkg::*;
#(
    parameter int unsigned p_mem_opaque_nbits = 8,
    parameter int unsigned p_mem_addr_nbits   = 32,
    parameter int unsigned p_mem_data_nbits   = 128,
    parameter int unsigned p_slot_cycles      = 4,
    parameter int unsigned p_max_outstanding  = 4
)(
    input  logic                         clk,
    input  logic                         reset,
    plab5_mcore_tdm_mem_arb_if.slave     req_in_p0,
    plab5_mcore_tdm_mem_arb_if.slave     req_in_p1,
    plab5_mcore_tdm_mem_arb_if.master    req_out,
    plab5_mcore_tdm_mem_arb_if.slave     resp_in,
    plab5_mcore_tdm_mem_arb_if.master    resp_out_p0,
    plab5_mcore_tdm_mem_arb_if.master    resp_out_p1
);
    localparam int unsigned mrqc = req_ctrl_nbits(p_mem_opaque_nbits, p_mem_addr_nbits,
                                                  p_mem_data_nbits);
    localparam int unsigned mrsc = resp_ctrl_nbits(p_mem_opaque_nbits, p_mem_data_nbits);
    localparam int unsigned cnt_nbits   = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam int unsigned slot_last_i = p_slot_cycles - 1;
    localparam logic [cnt_nbits-1:0] slot_last = slot_last_i[cnt_nbits-1:0];

    // Slot state
    logic [cnt_nbits-1:0] slot_cnt;
    port_id_e             slot_owner;
    logic                 issued;

    // Request path
    port_id_e                    grant_port;
    logic                        grant_en;
    logic                        sel_val;
    logic [mrqc-1:0]             sel_control;
    logic [p_mem_data_nbits-1:0] sel_data;
    logic                        sel_domain;
    logic                        fire;

    // Response path
    logic            q_full;
    logic            q_empty;
    logic            q_head;
    port_id_e        head_port;
    logic            resp_live;
    logic            head_rdy;
    logic            pop;
    logic [mrsc-1:0] resp_control;

`ifdef PLAB5_MCORE_TDM_ARB_WORK_CONSERVE_EN
    logic owner_val;
    // An idle owner hands the rest of its slot to the other port.
    assign owner_val  = (slot_owner == PORT_P1) ? req_in_p1.val : req_in_p0.val;
    assign grant_port = owner_val ? slot_owner : other_port(slot_owner);
`else
    // Strict TDM: only the slot owner is ever considered.
    assign grant_port = slot_owner;
`endif

    // A full owner queue blocks the grant even if a pop lands this cycle,
    // keeping the decision independent of response timing.
    assign grant_en = ~reset & ~issued & ~q_full;

    // Route the granted port onto the memory request channel.
    always_comb begin
        sel_val     = req_in_p0.val;
        sel_control = req_in_p0.control;
        sel_data    = req_in_p0.data;
        sel_domain  = req_in_p0.domain;
        if (grant_port == PORT_P1) begin
            sel_val     = req_in_p1.val;
            sel_control = req_in_p1.control;
            sel_data    = req_in_p1.data;
            sel_domain  = req_in_p1.domain;
        end
    end

    assign req_out.control = sel_control;
    assign req_out.data    = sel_data;
    assign req_out.domain  = sel_domain;
    assign req_out.val     = grant_en & sel_val;
    assign req_in_p0.rdy   = grant_en & (grant_port == PORT_P0) & req_out.rdy;
    assign req_in_p1.rdy   = grant_en & (grant_port == PORT_P1) & req_out.rdy;
    assign fire            = grant_en & sel_val & req_out.rdy;

    // Slot counter: wraps every p_slot_cycles, handing the slot to the other
    // port and re-arming the single-issue flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt   <= '0;
            slot_owner <= PORT_P0;
            issued     <= 1'b0;
        end else if (slot_cnt == slot_last) begin
            slot_cnt   <= '0;
            slot_owner <= other_port(slot_owner);
            issued     <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (fire) begin
                issued <= 1'b1;
            end
        end
    end

    plab5_mcore_tdm_owner_queue #(
        .p_depth (p_max_outstanding)
    ) u_owner_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (grant_port),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    // Responses return in issue order, so the queue head names the recipient.
    assign head_port    = port_id_e'(q_head);
    assign resp_live    = ~reset & ~q_empty;
    assign head_rdy     = (head_port == PORT_P1) ? resp_out_p1.rdy : resp_out_p0.rdy;
    assign resp_in.rdy  = resp_live & head_rdy;
    assign pop          = resp_in.val & resp_live & head_rdy;
    assign resp_control = resp_in.control;

    assign resp_out_p0.control = resp_control;
    assign resp_out_p0.data    = resp_in.data;
    assign resp_out_p0.domain  = resp_in.domain;
    assign resp_out_p0.val     = resp_live & resp_in.val & (head_port == PORT_P0);

    assign resp_out_p1.control = resp_control;
    assign resp_out_p1.data    = resp_in.data;
    assign resp_out_p1.domain  = resp_in.domain;
    assign resp_out_p1.val     = resp_live & resp_in.val & (head_port == PORT_P1);
endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_tdm_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plab5_mcore_tdm_mem_arb
//  Purpose  : Self-checking bench for the TDM memory arbiter (strict build).
//             Expected behaviour comes from a cycle-indexed slot model:
//             slot = t / S, owner = slot % 2, one issue per slot, and a
//             plain queue of owners for response steering.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plab5_mcore_tdm_mem_arb;
    localparam int S    = 4;
    localparam int D    = 4;
    localparam int L    = 128;
    localparam int MRQC = 3 + 8 + 32 + 4;   // type + opaque + addr + len
    localparam int MRSC = 3 + 8 + 4;        // type + opaque + len
    localparam int RQP  = MRQC + L + 1;
    localparam int RSP  = MRSC + L + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRQC), .p_data_nbits(L)) rq0 ();
    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRQC), .p_data_nbits(L)) rq1 ();
    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRQC), .p_data_nbits(L)) rqo ();
    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRSC), .p_data_nbits(L)) rsi ();
    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRSC), .p_data_nbits(L)) rs0 ();
    plab5_mcore_tdm_mem_arb_if #(.p_ctrl_nbits(MRSC), .p_data_nbits(L)) rs1 ();

    plab5_mcore_tdm_mem_arb #(
        .p_mem_opaque_nbits (8),
        .p_mem_addr_nbits   (32),
        .p_mem_data_nbits   (L),
        .p_slot_cycles      (S),
        .p_max_outstanding  (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in_p0   (rq0),
        .req_in_p1   (rq1),
        .req_out     (rqo),
        .resp_in     (rsi),
        .resp_out_p0 (rs0),
        .resp_out_p1 (rs1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int t;
    int last_slot;
    int q[$];
    int owner;
    int exp_head;
    bit exp_fire;
    bit exp_pop;
    logic [5:0]     exp_hs;
    logic [RQP-1:0] exp_req;

    function automatic logic [5:0] hs_obs();
        return {rqo.val, rq0.rdy, rq1.rdy, rsi.rdy, rs0.val, rs1.val};
    endfunction

    function automatic logic [RQP-1:0] req_obs();
        return {rqo.control, rqo.data, rqo.domain};
    endfunction

    function automatic logic [RSP-1:0] resp_obs(input int p);
        return (p == 1) ? {rs1.control, rs1.data, rs1.domain}
                        : {rs0.control, rs0.data, rs0.domain};
    endfunction

    function automatic logic [RSP-1:0] resp_src();
        return {rsi.control, rsi.data, rsi.domain};
    endfunction

    task automatic idle_inputs();
        rq0.val = 1'b0; rq1.val = 1'b0; rqo.rdy = 1'b0;
        rsi.val = 1'b0; rs0.rdy = 1'b0; rs1.rdy = 1'b0;
        rq0.control = '0; rq0.data = '0; rq0.domain = 1'b0;
        rq1.control = '0; rq1.data = '0; rq1.domain = 1'b0;
        rsi.control = '0; rsi.data = '0; rsi.domain = 1'b0;
    endtask

    task automatic rand_payloads();
        logic [63:0]  w;
        logic [127:0] d;
        w = {$urandom(), $urandom()}; d = {$urandom(), $urandom(), $urandom(), $urandom()};
        rq0.control = w[MRQC-1:0]; rq0.data = d[L-1:0]; rq0.domain = w[63];
        w = {$urandom(), $urandom()}; d = {$urandom(), $urandom(), $urandom(), $urandom()};
        rq1.control = w[MRQC-1:0]; rq1.data = d[L-1:0]; rq1.domain = w[63];
        w = {$urandom(), $urandom()}; d = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsi.control = w[MRSC-1:0]; rsi.data = d[L-1:0]; rsi.domain = w[63];
    endtask

    // Expected outputs for the current cycle from slot arithmetic and the owner queue.
    task automatic model_eval();
        int slot;
        bit allowed, e_rqv, e_r0, e_r1, e_ri, e_s0, e_s1, ov;
        slot    = t / S;
        owner   = slot % 2;
        allowed = !reset && (last_slot != slot) && (q.size() < D);
        ov      = (owner == 1) ? rq1.val : rq0.val;
        e_rqv   = allowed && ov;
        e_r0    = allowed && (owner == 0) && rqo.rdy;
        e_r1    = allowed && (owner == 1) && rqo.rdy;
        exp_fire = e_rqv && rqo.rdy;
        exp_req  = (owner == 1) ? {rq1.control, rq1.data, rq1.domain}
                                : {rq0.control, rq0.data, rq0.domain};
        e_ri = 1'b0; e_s0 = 1'b0; e_s1 = 1'b0; exp_head = -1;
        if (!reset && q.size() > 0) begin
            exp_head = q[0];
            e_s0 = (exp_head == 0) && rsi.val;
            e_s1 = (exp_head == 1) && rsi.val;
            e_ri = (exp_head == 1) ? rs1.rdy : rs0.rdy;
        end
        exp_pop = rsi.val && e_ri;
        exp_hs  = {e_rqv, e_r0, e_r1, e_ri, e_s0, e_s1};
    endtask

    task automatic model_commit();
        if (reset) begin
            t = 0; last_slot = -1; q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_fire) begin
                q.push_back(owner);
                last_slot = t / S;
            end
            t++;
        end
    endtask

    task automatic step();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        model_eval();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rq0.val = 1'b1; rq1.val = 1'b1; rqo.rdy = 1'b1;
        rsi.val = 1'b1; rs0.rdy = 1'b1; rs1.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hs cyc=%0d got %b want 000000", i, hs_obs());
            end
            step();
        end
        reset = 1'b0;
    endtask

    task automatic test_tdm_pattern();
        logic f;
        apply_reset();
        idle_inputs();
        rq0.val = 1'b1; rq1.val = 1'b1; rqo.rdy = 1'b1; rs0.rdy = 1'b1; rs1.rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL tdm_hs t=%0d got %b want %b", t, hs_obs(), exp_hs);
            end
            if (exp_hs[5]) begin
                n_cmp++;
                if (req_obs() !== exp_req) begin
                    n_fail++;
                    $display("FAIL tdm_req_payload t=%0d got %h want %h", t, req_obs(), exp_req);
                end
            end
            f = rqo.val & rqo.rdy;
            n_cmp++;
            if (f !== ((i % S) == 0)) begin
                n_fail++;
                $display("FAIL tdm_fire_slot t=%0d got %b want %b", t, f, ((i % S) == 0));
            end
            step();
        end
    endtask

    // Continues from the tdm pattern with four requests outstanding.
    task automatic test_full_queue();
        logic f;
        for (int i = 0; i < 12; i++) begin
            rsi.val = (i == 7);
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL full_hs t=%0d got %b want %b", t, hs_obs(), exp_hs);
            end
            if (exp_head >= 0) begin
                n_cmp++;
                if (resp_obs(exp_head) !== resp_src()) begin
                    n_fail++;
                    $display("FAIL full_resp_payload t=%0d got %h want %h", t, resp_obs(exp_head), resp_src());
                end
            end
            f = rqo.val & rqo.rdy;
            n_cmp++;
            if (f !== (i == 8)) begin
                n_fail++;
                $display("FAIL full_fire t=%0d got %b want %b", t, f, (i == 8));
            end
            step();
        end
        rsi.val = 1'b0;
    endtask

    task automatic test_resp_stall();
        int got[$];
        int want[4] = '{0, 1, 0, 1};
        apply_reset();
        idle_inputs();
        rq0.val = 1'b1; rq1.val = 1'b1; rqo.rdy = 1'b1; rs0.rdy = 1'b1; rs1.rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL stall_fill_hs t=%0d got %b want %b", t, hs_obs(), exp_hs);
            end
            step();
        end
        rq0.val = 1'b0; rq1.val = 1'b0; rsi.val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rs0.rdy = 1'b1;
            rs1.rdy = !(i >= 1 && i <= 3);
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL stall_hs t=%0d got %b want %b", t, hs_obs(), exp_hs);
            end
            if (exp_head >= 0) begin
                n_cmp++;
                if (resp_obs(exp_head) !== resp_src()) begin
                    n_fail++;
                    $display("FAIL stall_resp_payload t=%0d got %h want %h", t, resp_obs(exp_head), resp_src());
                end
            end
            if (i >= 1 && i <= 3) begin
                n_cmp++;
                if (rsi.rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_resp_in_rdy t=%0d got %b want 0", t, rsi.rdy);
                end
            end
            if (rs0.val === 1'b1 && rs0.rdy === 1'b1) got.push_back(0);
            if (rs1.val === 1'b1 && rs1.rdy === 1'b1) got.push_back(1);
            step();
        end
        rsi.val = 1'b0;
        n_cmp++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL stall_delivery_count got %0d want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] != want[k]) begin
                    n_fail++;
                    $display("FAIL stall_delivery_order idx=%0d got p%0d want p%0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        idle_inputs();
        rq0.val = 1'b1; rq1.val = 1'b1; rqo.rdy = 1'b1; rsi.val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reset = (i == 6);
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL midrst_hs cyc=%0d got %b want %b", i, hs_obs(), exp_hs);
            end
            if (i == 7) begin
                n_cmp++;
                if ({rq0.rdy, rq1.rdy, rsi.rdy, rs0.val, rs1.val} !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL midrst_after got %b want 10000",
                             {rq0.rdy, rq1.rdy, rsi.rdy, rs0.val, rs1.val});
                end
            end
            step();
        end
        reset = 1'b0;
        rsi.val = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 127) == 0);
            rq0.val = ($urandom_range(0, 3) != 0);
            rq1.val = ($urandom_range(0, 3) != 0);
            rqo.rdy = ($urandom_range(0, 9) < 7);
            rsi.val = ($urandom_range(0, 9) < 4);
            rs0.rdy = ($urandom_range(0, 9) < 7);
            rs1.rdy = ($urandom_range(0, 9) < 7);
            rand_payloads();
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (hs_obs() !== exp_hs) begin
                n_fail++;
                $display("FAIL rand_hs cyc=%0d t=%0d got %b want %b", i, t, hs_obs(), exp_hs);
            end
            if (exp_hs[5]) begin
                n_cmp++;
                if (req_obs() !== exp_req) begin
                    n_fail++;
                    $display("FAIL rand_req_payload cyc=%0d got %h want %h", i, req_obs(), exp_req);
                end
            end
            if (exp_head >= 0) begin
                n_cmp++;
                if (resp_obs(exp_head) !== resp_src()) begin
                    n_fail++;
                    $display("FAIL rand_resp_payload cyc=%0d got %h want %h", i, resp_obs(exp_head), resp_src());
                end
            end
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        t = 0;
        last_slot = -1;
        @(posedge clk);
        #1;
        test_reset();
        test_tdm_pattern();
        test_full_queue();
        test_resp_stall();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/plab5_mcore_tdm_mem_arb.md
# plab5_mcore_tdm_mem_arb

Security-domain-aware time-division-multiplexed arbiter that shares one memory request/response port between two requesting ports, typically the two core-side ports of a MemNet bank or two cache refill paths. Grant order depends only on a free-running slot counter, never on the other port's traffic, so one domain cannot modulate the other's memory latency. An owner queue records the issuing port of each request and returns each in-order response to that port.

## Interface
Parameters:
- p_mem_opaque_nbits, 8, opaque field width (o)
- p_mem_addr_nbits, 32, address width (a)
- p_mem_data_nbits, 128, line data width (l); control width mrqc = VC_MEM_REQ_MSG_NBITS(o,a,l) - l, mrsc = VC_MEM_RESP_MSG_NBITS(o,l) - l
- p_slot_cycles, 4, cycles per TDM slot, >= 2
- p_max_outstanding, 4, owner-queue depth, power of 2

Ports (one clock `clk`; reset is synchronous and active-high, named `reset`):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_in_control_p{0,1}  in  mrqc  request control
- req_in_data_p{0,1}  in  l  request data
- req_in_domain_p{0,1}  in  1  request security domain
- req_in_val_p{0,1} in 1 / req_in_rdy_p{0,1} out 1  request handshake
- req_out_control / req_out_data / req_out_domain  out  mrqc / l / 1  granted request
- req_out_val out 1 / req_out_rdy in 1  memory request handshake
- resp_in_control / resp_in_data / resp_in_domain  in  mrsc / l / 1  memory response
- resp_in_val in 1 / resp_in_rdy out 1  memory response handshake
- resp_out_control_p{0,1} / resp_out_data_p{0,1} / resp_out_domain_p{0,1}  out  mrsc / l / 1
- resp_out_val_p{0,1} out 1 / resp_out_rdy_p{0,1} in 1

## Operation
- State: slot_cnt (0..p_slot_cycles-1), slot_owner (1 bit), issued (1 bit), owner queue.
- slot_cnt increments every cycle. At p_slot_cycles-1 it wraps to 0, toggles slot_owner and clears issued.
- Grant condition: port i = slot_owner, !issued, owner queue not full.
- When granted: req_out_* = port i's fields; req_out_val = req_in_val_pi; req_in_rdy_pi = req_out_rdy. The non-owner's rdy is 0.
- On fire (req_out_val & req_out_rdy): push i into the owner queue and set issued. At most one request per slot.
- Full queue: no grant, even if a pop happens in the same cycle. The slot is not extended.
- Response routing: head = queue head.
  - resp_out_val_p[head] = resp_in_val & !empty; all resp_out_* fields pass through, including domain.
  - resp_in_rdy = resp_out_rdy_p[head] & !empty. The other port's val is 0.
  - Pop on resp_in_val & resp_in_rdy.
- Empty queue with resp_in_val high: resp_in_rdy = 0 (stall, protocol error).
- Push and pop in the same cycle with the queue not full: both take effect; the count is unchanged.
- Reset mid-operation clears the queue, slot_cnt, slot_owner and issued. The memory side must be reset in the same cycle.

## Timing
- Reset values:
  - slot_cnt = 0, slot_owner = 0, issued = 0, queue empty.
  - All val/rdy outputs are 0 in the reset cycle.
  - After reset deassertion, rdy and val follow the combinational rules above.
- Request path is combinational, 0-cycle; response path is combinational, 0-cycle.
- A port waits at most 2*p_slot_cycles-1 cycles for an issue opportunity, independent of the other port.
- Throughput: 1 request per p_slot_cycles cycles aggregate.

## Configuration
- PLAB5_MCORE_TDM_ARB_WORK_CONSERVE_EN.
- Defined: when the slot owner has req_in_val = 0 and !issued, the non-owner may be granted in that slot under the same single-issue rule. This gives higher throughput but leaks timing across domains; for non-secure builds only.
- Undefined: strict TDM. The non-owner is never granted.

## Structure
- A shared defines header holds:
  - the control/response width macros (reused VC_MEM_* macros);
  - port-ID encodings PLAB5_MCORE_TDM_PORT0/PORT1.
- One sub-module, plab5_mcore_tdm_owner_queue: 1-bit-wide, p_max_outstanding-deep FIFO with push, pop, full, empty and head.

## Test plan
- Both ports continuously valid, mem always ready, p_slot_cycles=4 -> grants at cycles 0 (p0), 4 (p1), 8 (p0), exactly one fire per slot.
- p1 valid at cycle 1 only, p0 idle -> p1 fires at cycle 4; with WORK_CONSERVE_EN it fires at cycle 1.
- Mem req_out_rdy=0 for 6 cycles from cycle 0 -> p0 fires only if rdy rises by cycle 3; otherwise p1 gets the slot at cycle 4.
- Issue p0, p1, p0, p1 with responses returned in order, resp_out_rdy_p1=0 for 3 cycles -> responses reach p0, p1 (after stall), p0, p1; resp_in_rdy low during the stall.
- 4 outstanding, no responses -> no grant at the fifth slot; a response pop re-enables the grant at the next slot.
- Assert reset at cycle 6 with 2 outstanding -> next cycle slot_cnt=0, owner=0, queue empty, resp_out_val=0.
